store_align_queue: RTL and testbench

STORE_ALIGN_QUEUE -- requirements
Module: store_align_queue

---
 rtl/store_align_queue_pkg.sv | 40 ++++
 rtl/store_align_queue_if.sv | 35 +++
 rtl/store_align_queue_lane_align.sv | 36 +++
 rtl/store_align_queue.sv | 107 ++++++++++
 tb/tb_store_align_queue.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/store_align_queue_pkg.sv
// ============================================================================
// Module      : cpuDefine (package)
// Description : Store size encoding and lane strobe/shift helpers.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cpuDefine;

    localparam int ADDR_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE  = 2'd0,
        SIZE_HALF  = 2'd1,
        SIZE_WORD  = 2'd2,
        SIZE_DWORD = 2'd3
    } store_size_e;

    // Computed over 8 lanes; narrower buses truncate the result.
    function automatic logic [7:0] lane_strobe(input logic [2:0] offset, input logic [1:0] size);
        logic [15:0] w_ones;
        w_ones = (16'd1 << (16'd1 << size)) - 16'd1;
        return 8'(w_ones << offset);
    endfunction

    function automatic logic [63:0] lane_shift(input logic [63:0] data, input logic [2:0] offset,
                                               input logic [1:0] size);
        logic [63:0] w_kept;
        w_kept = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < (4'd1 << size)) begin
                w_kept[8*i +: 8] = data[8*i +: 8];
            end
        end
        return w_kept << {offset, 3'b000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/store_align_queue_if.sv
// ============================================================================
// Module      : store_align_queue_if
// Description : Store request and aligned memory-write handshake bundle.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface store_align_queue_if #(
    parameter int DATA_W = 32
);
    import cpuDefine::*;

    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_W-1:0]     in_addr;
    logic [1:0]            in_size;
    logic [DATA_W-1:0]     in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_W-1:0]     out_addr;
    logic [DATA_W/8-1:0]   out_wstrb;
    logic [DATA_W-1:0]     out_data;

    modport master (
        output in_valid, in_addr, in_size, in_data, out_ready,
        input  in_ready, out_valid, out_addr, out_wstrb, out_data
    );

    modport slave (
        input  in_valid, in_addr, in_size, in_data, out_ready,
        output in_ready, out_valid, out_addr, out_wstrb, out_data
    );
endinterface

`default_nettype wire

// File: rtl/store_align_queue_lane_align.sv
// ============================================================================
// Module      : store_lane_align
// Description : Combinational byte-lane strobe, data shift and misalign check.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module store_lane_align
    import cpuDefine::*;
#(
    parameter int DATA_W = 32,
    parameter int LANES  = DATA_W / 8,
    parameter int OFF_W  = $clog2(LANES)
) (
    input  wire logic [OFF_W-1:0]  offset,
    input  wire logic [1:0]        size,
    input  wire logic [DATA_W-1:0] data_in,
    output logic      [LANES-1:0]  wstrb,
    output logic      [DATA_W-1:0] data_out,
    output logic                   misalign
);

    logic [2:0] w_off3;
    logic [2:0] w_bytes_m1;

    assign w_off3     = 3'(offset);
    assign w_bytes_m1 = 3'((4'd1 << size) - 4'd1);

    // A dword never fits a 4-lane bus regardless of offset.
    assign misalign = (|(w_off3 & w_bytes_m1)) || ((LANES < 8) && (size == SIZE_DWORD));
    assign wstrb    = LANES'(lane_strobe(w_off3, size));
    assign data_out = DATA_W'(lane_shift(64'(data_in), w_off3, size));

endmodule

`default_nettype wire

// File: rtl/store_align_queue.sv
// ============================================================================
// Module      : store_align_queue
// Description : Aligns store requests to bus lanes and buffers them in a FIFO.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module store_align_queue
    import cpuDefine::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  wire logic                   clk,
    input  wire logic                   rst_n,
    input  wire logic                   flush,
    store_align_queue_if.slave          bus,
    output logic                        misalign_err,
    output logic [$clog2(DEPTH):0]      count
);

    localparam int LANES = DATA_W / 8;
    localparam int OFF_W = $clog2(LANES);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [LANES-1:0]  r_mem_strb [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_misalign_err;

    logic [LANES-1:0]  w_strb;
    logic [DATA_W-1:0] w_data;
    logic              w_misalign;
    logic [ADDR_W-1:0] w_addr;
    logic              w_hs;
    logic              w_enq;
    logic              w_deq;

    store_lane_align #(
        .DATA_W (DATA_W)
    ) u_lane_align (
        .offset   (bus.in_addr[OFF_W-1:0]),
        .size     (bus.in_size),
        .data_in  (bus.in_data),
        .wstrb    (w_strb),
        .data_out (w_data),
        .misalign (w_misalign)
    );

    assign w_addr = {bus.in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign w_hs   = bus.in_valid && bus.in_ready;
    assign w_enq  = w_hs && !w_misalign && !flush;
    assign w_deq  = bus.out_valid && bus.out_ready && !flush;

    // Head is read straight from storage, so an empty queue has no input-to-output path.
    assign bus.in_ready  = (r_count != CNT_W'(DEPTH));
    assign bus.out_valid = (r_count != '0);
    assign bus.out_addr  = r_mem_addr[r_rd_ptr];
    assign bus.out_wstrb = r_mem_strb[r_rd_ptr];
    assign bus.out_data  = r_mem_data[r_rd_ptr];
    assign misalign_err  = r_misalign_err;
    assign count         = r_count;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem_addr[r_wr_ptr] <= w_addr;
            r_mem_strb[r_wr_ptr] <= w_strb;
            r_mem_data[r_wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_misalign_err <= 1'b0;
        end else begin
            r_misalign_err <= w_hs && w_misalign;
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_enq) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_deq) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_enq && !w_deq) begin
                    r_count <= r_count + 1'b1;
                end else if (w_deq && !w_enq) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_store_align_queue.sv
// ============================================================================
// Module      : tb_store_align_queue
// Description : Directed scoreboard bench for store_align_queue (32- and 64-bit).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_store_align_queue;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       flush;
    logic       flush64;
    logic       misalign_err;
    logic       misalign_err64;
    logic [2:0] count;
    logic [2:0] count64;

    int   n_checks = 0;
    int   n_err    = 0;
    bit   exp_err;
    exp_t sb[$];

    store_align_queue_if #(.DATA_W(32)) bus ();
    store_align_queue_if #(.DATA_W(64)) bus64 ();

    store_align_queue #(.DATA_W(32), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .misalign_err (misalign_err),
        .count        (count)
    );

    store_align_queue #(.DATA_W(64), .DEPTH(DEPTH)) dut64 (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush64),
        .bus          (bus64),
        .misalign_err (misalign_err64),
        .count        (count64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic [31:0] addr, input logic [1:0] size,
                                  input logic [63:0] data, input int lanes,
                                  output bit mis, output logic [7:0] strb,
                                  output logic [63:0] d, output logic [31:0] a);
        int nb;
        int off;
        nb   = 1 << size;
        off  = int'(addr % lanes);
        mis  = ((off % nb) != 0) || (nb > lanes);
        strb = '0;
        d    = '0;
        a    = addr - 32'(off);
        if (!mis) begin
            for (int i = 0; i < nb; i++) begin
                strb[off+i]          = 1'b1;
                d[8*(off+i) +: 8]    = data[8*i +: 8];
            end
        end
    endfunction

    task automatic drive(input bit v, input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_addr  = a;
        bus.in_size  = s;
        bus.in_data  = d;
    endtask

    // One clock on the 32-bit DUT with scoreboard bookkeeping.
    task automatic tick();
        bit          hs;
        bit          mis;
        logic [7:0]  s;
        logic [63:0] d;
        logic [31:0] a;
        exp_t        e;
        chk("in_ready", bus.in_ready, sb.size() != DEPTH);
        model(bus.in_addr, bus.in_size, 64'(bus.in_data), 4, mis, s, d, a);
        hs = bus.in_valid && (sb.size() != DEPTH);
        if (!flush && sb.size() != 0 && bus.out_ready) begin
            e = sb.pop_front();
            chk("head_addr", bus.out_addr, e.addr);
            chk("head_wstrb", bus.out_wstrb, e.strb);
            chk("head_data", bus.out_data, e.data);
        end
        if (flush) begin
            sb.delete();
        end else if (hs && !mis) begin
            sb.push_back('{a, s[3:0], d[31:0]});
        end
        exp_err = hs && mis;
        @(posedge clk);
        #1;
        chk("misalign_err", misalign_err, exp_err);
        chk("count", count, sb.size());
        chk("out_valid", bus.out_valid, sb.size() != 0);
    endtask

    initial begin
        logic [31:0] ta [5];
        logic [1:0]  ts [5];
        logic [31:0] td [5];
        ta = '{32'h100, 32'h202, 32'h304, 32'h401, 32'h508};
        ts = '{2'd2, 2'd1, 2'd2, 2'd0, 2'd2};
        td = '{32'h11223344, 32'h0000BEEF, 32'hCAFEF00D, 32'h0000005A, 32'h0BADC0DE};

        rst_n = 1'b0;
        flush = 1'b0;
        flush64 = 1'b0;
        drive(0, 32'h0, 2'd0, 32'h0);
        bus.out_ready   = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.in_addr   = '0;
        bus64.in_size   = '0;
        bus64.in_data   = '0;
        bus64.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_misalign", misalign_err, 0);
        chk("rst_out_valid64", bus64.out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Byte store into the top lane
        drive(1, 32'h1003, 2'd0, 32'h000000AB);
        tick();
        drive(0, 32'h0, 2'd0, 32'h0);
        chk("byte_addr", bus.out_addr, 32'h1000);
        chk("byte_wstrb", bus.out_wstrb, 4'b1000);
        chk("byte_data", bus.out_data, 32'hAB000000);
        bus.out_ready = 1'b1;
        tick();

        // Misaligned half, then dword on a 32-bit bus
        bus.out_ready = 1'b0;
        drive(1, 32'h2001, 2'd1, 32'h1234);
        tick();
        drive(0, 32'h0, 2'd0, 32'h0);
        tick();
        drive(1, 32'h3000, 2'd3, 32'hDEADBEEF);
        tick();
        drive(0, 32'h0, 2'd0, 32'h0);
        tick();

        // Fill to full, hold the fifth request, then drain
        for (int i = 0; i < 5; i++) begin
            drive(1, ta[i], ts[i], td[i]);
            tick();
        end
        chk("full_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        tick();
        tick();
        drive(0, 32'h0, 2'd0, 32'h0);
        repeat (4) tick();

        // Random refill with wrapping pointers
        for (int i = 0; i < 12; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            drive(1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)), $urandom);
            tick();
        end
        drive(0, 32'h0, 2'd0, 32'h0);
        bus.out_ready = 1'b1;
        repeat (6) tick();

        // Flush with three entries queued and a valid request present
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h600 + 32'(4 * i), 2'd2, 32'hA0A0A000 + 32'(i));
            tick();
        end
        flush = 1'b1;
        drive(1, 32'h700, 2'd2, 32'h77777777);
        tick();
        drive(1, 32'h701, 2'd2, 32'h77777777);
        tick();
        flush = 1'b0;
        drive(1, 32'h802, 2'd1, 32'h0000C0DE);
        bus.out_ready = 1'b1;
        tick();
        drive(0, 32'h0, 2'd0, 32'h0);
        tick();

        // Asynchronous reset in the middle of a drain
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h900 + 32'(i), 2'd0, 32'h000000F0 + 32'(i));
            tick();
        end
        drive(0, 32'h0, 2'd0, 32'h0);
        bus.out_ready = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_count", count, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_out_valid", bus.out_valid, 0);
        drive(1, 32'hA04, 2'd2, 32'h13579BDF);
        tick();
        drive(0, 32'h0, 2'd0, 32'h0);
        tick();

        // 64-bit bus: full dword, offset byte, misaligned dword
        bus.out_ready   = 1'b0;
        bus64.in_valid  = 1'b1;
        bus64.in_addr   = 32'h10;
        bus64.in_size   = 2'd3;
        bus64.in_data   = 64'h1122334455667788;
        @(posedge clk);
        #1;
        chk("d64_addr", bus64.out_addr, 32'h10);
        chk("d64_wstrb", bus64.out_wstrb, 8'hFF);
        chk("d64_data", bus64.out_data, 64'h1122334455667788);
        bus64.in_addr   = 32'h15;
        bus64.in_size   = 2'd0;
        bus64.in_data   = 64'h00000000000000CD;
        @(posedge clk);
        #1;
        bus64.in_valid  = 1'b0;
        bus64.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("b64_count", count64, 1);
        chk("b64_addr", bus64.out_addr, 32'h10);
        chk("b64_wstrb", bus64.out_wstrb, 8'h20);
        chk("b64_data", bus64.out_data, 64'h0000CD0000000000);
        @(posedge clk);
        #1;
        chk("b64_empty", count64, 0);
        bus64.in_valid  = 1'b1;
        bus64.in_addr   = 32'h14;
        bus64.in_size   = 2'd3;
        @(posedge clk);
        #1;
        bus64.in_valid  = 1'b0;
        chk("m64_err", misalign_err64, 1);
        chk("m64_count", count64, 0);
        @(posedge clk);
        #1;
        chk("m64_err_clear", misalign_err64, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
